// File: rtl/multiword_add_seq.sv
// ============================================================================
// Module   : multiword_add_seq (with helper kogge_stone_adder)
// Purpose  : Multi-precision add/subtract sequencer. A WORDS x 16-bit operand
//            pair is accepted over a valid/ready handshake and fed through a
//            single shared 16-bit Kogge-Stone adder, one word per cycle,
//            least-significant word first, with the carry chained between
//            words. The full-width result is returned with carry-out and
//            signed-overflow flags.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            in_valid   request valid
//            in_ready   request can be accepted (high only in IDLE)
//            op_sub     0 = A+B, 1 = A-B (sampled at accept)
//            a, b       N-bit operands, N = 16*WORDS (sampled at accept)
//            out_valid  result valid (high only in DONE)
//            out_ready  consumer accepts the result
//            sum        N-bit result
//            cout       carry out of bit N-1 (not-borrow for subtract)
//            overflow   signed two's-complement overflow
// Options  : `define ADDSEQ_SATURATE_EN to clamp an overflowing result to the
//            most positive / most negative N-bit value on entry to DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// kogge_stone_adder: 16-bit parallel-prefix adder with carry in/out.
// The carry-in is folded into the bit-0 generate term so the prefix tree
// directly yields the carry into every bit position.
// ----------------------------------------------------------------------------
module kogge_stone_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] w_h;       // half-sum (bitwise propagate)
  logic [15:0] w_gc;      // group generate for bits [i:0] including cin

  assign w_h = a_i ^ b_i;

  // Log2(16) = 4 prefix levels with spans 1, 2, 4, 8.
  always_comb begin : p_prefix
    logic [15:0] g_lvl;
    logic [15:0] p_lvl;
    logic [15:0] g_nxt;
    logic [15:0] p_nxt;
    g_lvl = (a_i & b_i) | {15'b0, w_h[0] & cin_i};
    p_lvl = w_h;
    g_nxt = g_lvl;
    p_nxt = p_lvl;
    for (int d = 1; d < 16; d = d * 2) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = d; i < 16; i++) begin
        g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i-d]);
        p_nxt[i] = p_lvl[i] & p_lvl[i-d];
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    w_gc = g_lvl;
  end

  // Carry into bit i is the group generate of bits [i-1:0]; bit 0 sees cin.
  assign sum_o  = w_h ^ {w_gc[14:0], cin_i};
  assign cout_o = w_gc[15];

endmodule

// ----------------------------------------------------------------------------
// multiword_add_seq: top-level sequencer.
// ----------------------------------------------------------------------------
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  overflow
);

  localparam int N  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;        // holds b already inverted for subtract
  logic [N-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [15:0]     w_a_word;
  logic [15:0]     w_b_word;
  logic [15:0]     w_s_word;
  logic            w_add_cout;
  logic            w_ovf;
  logic            w_last;

  // --------------------------------------------------------------------------
  // Word select for the current index. A decoded mux keeps the index width
  // independent of the operand width (including WORDS = 1).
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IW'(w)) begin
        w_a_word = a_q[16*w +: 16];
        w_b_word = b_q[16*w +: 16];
      end
    end
  end

  kogge_stone_adder u_adder (
    .a_i    (w_a_word),
    .b_i    (w_b_word),
    .cin_i  (carry_q),
    .sum_o  (w_s_word),
    .cout_o (w_add_cout)
  );

  assign w_last = (idx_q == LAST_IDX);

  // Overflow uses the effective B (already inverted for subtract), so one
  // rule covers both operations: same-sign inputs giving a different-sign
  // result. Only meaningful on the top word.
  assign w_ovf = (w_a_word[15] == w_b_word[15]) && (w_s_word[15] != w_a_word[15]);

`ifdef ADDSEQ_SATURATE_EN
  logic [N-1:0] w_clamp;
  // Overflow implies the true sign equals the sign of A.
  assign w_clamp = w_a_word[15] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath update.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtract as A + ~B + 1: the +1 enters as the initial carry.
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IW'(w)) begin
            sum_d[16*w +: 16] = w_s_word;
          end
        end
        carry_d = w_add_cout;
        if (w_last) begin
          cout_d  = w_add_cout;
          ovf_d   = w_ovf;
          state_d = S_DONE;
`ifdef ADDSEQ_SATURATE_EN
          if (w_ovf) begin
            sum_d = w_clamp;
          end
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
// ============================================================================
// Module   : tb_multiword_add_seq
// Purpose  : Self-checking bench for multiword_add_seq. Expected results come
//            from a plain-arithmetic reference model and are queued at accept
//            time; a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  // Reference: unsigned N+1-bit arithmetic for sum/carry, signed N+1-bit
  // arithmetic for overflow and saturation.
  function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                 input logic sub);
    logic        [N:0] u;
    logic signed [N:0] sa;
    logic signed [N:0] sb;
    logic signed [N:0] sr;
    exp_t e;
    sa = {ta[N-1], ta};
    sb = {tb[N-1], tb};
    if (sub) begin
      u  = {1'b0, ta} - {1'b0, tb};
      sr = sa - sb;
    end else begin
      u  = {1'b0, ta} + {1'b0, tb};
      sr = sa + sb;
    end
    e.s = u[N-1:0];
    e.c = sub ? ~u[N] : u[N];         // subtract: 1 when no borrow
    e.v = (sr[N] != sr[N-1]);         // true result outside N-bit signed range
`ifdef ADDSEQ_SATURATE_EN
    if (e.v) e.s = sr[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got sum %0h with no request outstanding", sum);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum", sum, mon_e.s);
        chk("cout", cout, mon_e.c);
        chk("overflow", overflow, mon_e.v);
      end
    end
  end

  // Random consumer backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic ts, input bit push);
    int guard;
    @(negedge clk);
    a        = ta;
    b        = tb;
    op_sub   = ts;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb_q.push_back(model(ta, tb, ts));
    #1;
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is observed.
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid && k < 60);
  endtask

  logic [N-1:0] ta_r, tb_r, nb_a, nb_b;
  logic [N+1:0] cap;
  int           lat;
  bit           seen;
  int           guard;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sum", 128'(sum), 128'(0));
    chk("rst_cout", 128'(cout), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    rst = 1'b0;

    // Directed cases with latency check.
    issue({N{1'b1}}, 64'h1, 1'b0, 1'b1);
    wait_valid(lat);
    chk("latency_add_wrap", 128'(lat), 128'(WORDS));

    issue(64'h0, 64'h1, 1'b1, 1'b1);
    wait_valid(lat);
    chk("latency_sub_borrow", 128'(lat), 128'(WORDS));

    issue(64'h0001_0000_0000_0000, 64'h0000_FFFF_0000_0001, 1'b1, 1'b1);
    wait_valid(lat);
    chk("latency_sub_chain", 128'(lat), 128'(WORDS));

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    wait_valid(lat);
    chk("latency_pos_ovf", 128'(lat), 128'(WORDS));

    issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
    wait_valid(lat);
    chk("latency_neg_ovf", 128'(lat), 128'(WORDS));

    // Backpressure: result held, new request ignored until released.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    wait_valid(lat);
    chk("latency_bp", 128'(lat), 128'(WORDS));
    cap  = {sum, cout, overflow};
    nb_a = 64'hDEAD_BEEF_0000_FFFF;
    nb_b = 64'h0000_0001_FFFF_0001;
    @(negedge clk);
    a        = nb_a;
    b        = nb_b;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {in_ready, out_valid, sum, cout, overflow}, {2'b01, cap});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {in_ready, out_valid}, 128'(2'b10));
    @(posedge clk);
    sb_q.push_back(model(nb_a, nb_b, 1'b1));
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("latency_held_req", 128'(lat), 128'(WORDS));

    // Reset mid-RUN (idx = 2): request aborted, never reported.
    @(posedge clk);
    #1;
    issue(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_state", {in_ready, out_valid, sum, cout, overflow}, {2'b10, {(N+2){1'b0}}});
    seen = 1'b0;
    repeat (WORDS + 3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 128'(seen), 128'(0));

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ta_r = {$urandom, $urandom};
      tb_r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ta_r = {1'b0, {(N-1){1'b1}}};
        1: tb_r = {1'b1, {(N-1){1'b0}}};
        2: tb_r = ta_r;
        default: ;
      endcase
      issue(ta_r, tb_r, 1'($urandom_range(0, 1)), 1'b1);
    end

    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_outstanding", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
